rtp_ray_dispatch_ctrl: RTL and testbench

// - Sequences a ray batch through the RTP traversal/intersection pipeline: issues ray IDs
//   0..num_rays-1 into the pipeline input, caps in-flight rays with a credit counter,

---
 rtl/rtp_ray_dispatch_ctrl.sv | 129 ++++++++++++
 tb/tb_rtp_ray_dispatch_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtp_ray_dispatch_ctrl.sv
// Ray batch dispatcher: issues IDs 0..num_rays-1 under an in-flight credit cap, retires
// completions into the result RAM. `RTP_PERF_CNT_EN adds perf_cycles/perf_stalls outputs.
module rtp_ray_dispatch_ctrl #(
  parameter int RAY_W        = 16,
  parameter int MAX_INFLIGHT = 8,
  parameter int IF_W         = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [RAY_W-1:0] num_rays,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [RAY_W-1:0] issue_ray_id,
  input  logic             cmpl_valid,
  input  logic [RAY_W-1:0] cmpl_ray_id,
  input  logic [31:0]      cmpl_hitT,
  output logic             res_we,
  output logic [RAY_W-1:0] res_addr,
  output logic [31:0]      res_data,
  output logic [IF_W-1:0]  inflight,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef RTP_PERF_CNT_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IF_W-1:0] CAP = IF_W'(MAX_INFLIGHT);

  logic [1:0]     state;
  // One extra bit so a batch of 2**RAY_W-1 rays never wraps the compare.
  logic [RAY_W:0] num_q;
  logic [RAY_W:0] issued;
  logic [RAY_W:0] retired;
  logic [RAY_W:0] issued_nxt;
  logic [RAY_W:0] retired_nxt;
  logic           active;
  logic           xfer;
  logic           cmpl_ok;
  logic           cmpl_bad;

  assign active       = (state == S_ISSUE) || (state == S_DRAIN);
  assign issue_valid  = (state == S_ISSUE) && (inflight < CAP);
  assign issue_ray_id = issued[RAY_W-1:0];
  assign xfer         = issue_valid && issue_ready;
  assign cmpl_ok      = active && cmpl_valid && (inflight != '0);
  assign cmpl_bad     = active && cmpl_valid && (inflight == '0);
  assign issued_nxt   = issued + (RAY_W+1)'(xfer);
  assign retired_nxt  = retired + (RAY_W+1)'(cmpl_ok);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      num_q    <= '0;
      issued   <= '0;
      retired  <= '0;
      inflight <= '0;
      err      <= 1'b0;
      res_we   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
    end else begin
      res_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_q    <= {1'b0, num_rays};
            issued   <= '0;
            retired  <= '0;
            inflight <= '0;
            err      <= 1'b0;
            state    <= (num_rays == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE, S_DRAIN: begin
          issued   <= issued_nxt;
          retired  <= retired_nxt;
          inflight <= inflight + IF_W'(xfer) - IF_W'(cmpl_ok);
          // A completion with nothing outstanding is a pipeline bug: flag it, never wrap.
          if (cmpl_bad) begin
            err <= 1'b1;
          end
          if (cmpl_ok) begin
            res_we   <= 1'b1;
            res_addr <= cmpl_ray_id;
            res_data <= cmpl_hitT;
          end
          if ((state == S_ISSUE) && (issued_nxt == num_q)) begin
            state <= S_DRAIN;
          end else if ((state == S_DRAIN) && (retired_nxt == num_q)) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RTP_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if ((state == S_IDLE) && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (active) begin
      if (perf_cycles != 32'hFFFF_FFFF) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if (issue_valid && !issue_ready && (perf_stalls != 32'hFFFF_FFFF)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rtp_ray_dispatch_ctrl.sv
// Bench for rtp_ray_dispatch_ctrl: directed scenarios then random batches, every cycle
// compared against a count-based reference model.
module tb_rtp_ray_dispatch_ctrl;

  localparam int RAY_W = 16;
  localparam int MAXI  = 4;
  localparam int IF_W  = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset, start, issue_ready, cmpl_valid;
  logic [RAY_W-1:0] num_rays, cmpl_ray_id;
  logic [31:0]      cmpl_hitT;
  logic             issue_valid, res_we, busy, done, err;
  logic [RAY_W-1:0] issue_ray_id, res_addr;
  logic [31:0]      res_data;
  logic [IF_W-1:0]  inflight;
`ifdef RTP_PERF_CNT_EN
  logic [31:0]      perf_cycles, perf_stalls;
`endif

  rtp_ray_dispatch_ctrl #(.RAY_W(RAY_W), .MAX_INFLIGHT(MAXI), .IF_W(IF_W)) dut (
    .clock(clock), .reset(reset), .start(start), .num_rays(num_rays),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ray_id(issue_ray_id),
    .cmpl_valid(cmpl_valid), .cmpl_ray_id(cmpl_ray_id), .cmpl_hitT(cmpl_hitT),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .inflight(inflight), .busy(busy), .done(done), .err(err)
`ifdef RTP_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int w_cnt = 0;
  int d_cnt = 0;

  // Reference model: batch progress as plain counts of issued/retired rays.
  bit               m_busy, m_done, m_err, m_we;
  int               m_num, m_issued, m_retired;
  logic [RAY_W-1:0] m_addr;
  logic [31:0]      m_data, m_cycles, m_stalls;
  int               pend_id[$];
  int               pend_t[$];

  function automatic bit m_iv();
    return m_busy && !m_done && (m_issued < m_num) && ((m_issued - m_retired) < MAXI);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit iv;
    int infl;
    infl = m_issued - m_retired;
    iv   = m_iv();
    @(posedge clock);
    if (reset) begin
      m_busy = 0; m_done = 0; m_err = 0; m_we = 0;
      m_num = 0; m_issued = 0; m_retired = 0;
      m_addr = '0; m_data = '0; m_cycles = '0; m_stalls = '0;
      pend_id.delete(); pend_t.delete();
    end else if (!m_busy) begin
      m_we = 0;
      if (start) begin
        m_busy = 1; m_num = int'(num_rays); m_issued = 0; m_retired = 0; m_err = 0;
        m_cycles = '0; m_stalls = '0; m_done = (num_rays == '0);
        pend_id.delete(); pend_t.delete();
      end
    end else if (m_done) begin
      m_busy = 0; m_done = 0; m_we = 0;
    end else begin
      if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
      if (iv && !issue_ready && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      m_we = 0;
      if (cmpl_valid) begin
        if (infl == 0) m_err = 1;
        else begin
          m_retired++; m_we = 1; m_addr = cmpl_ray_id; m_data = cmpl_hitT;
        end
      end
      if (iv && issue_ready) begin
        pend_id.push_back(m_issued); pend_t.push_back(cyc + 1); m_issued++;
      end
      if (m_issued == m_num && m_retired == m_num) m_done = 1;
    end
    #1;
    cyc++;
    if (res_we === 1'b1) w_cnt++;
    if (done === 1'b1) d_cnt++;
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("err", err, m_err);
    check("inflight", inflight, IF_W'(m_issued - m_retired));
    check("issue_valid", issue_valid, m_iv());
    check("issue_ray_id", issue_ray_id, RAY_W'(m_issued));
    check("res_we", res_we, m_we);
    check("res_addr", res_addr, m_addr);
    check("res_data", res_data, m_data);
`ifdef RTP_PERF_CNT_EN
    check("perf_cycles", perf_cycles, m_cycles);
    check("perf_stalls", perf_stalls, m_stalls);
`endif
  endtask

  task automatic drive_cmpl(input int lat, input int pct, input bit inorder, input bit spurious);
    cmpl_valid = 1'b0;
    if (pend_id.size() != 0 && $urandom_range(99) < pct) begin
      int i;
      i = inorder ? 0 : $urandom_range(pend_id.size() - 1);
      if (cyc + 1 - pend_t[i] >= lat) begin
        cmpl_valid  = 1'b1;
        cmpl_ray_id = RAY_W'(pend_id[i]);
        cmpl_hitT   = $urandom;
        pend_id.delete(i); pend_t.delete(i);
      end
    end else if (spurious && pend_id.size() == 0 && $urandom_range(7) == 0) begin
      cmpl_valid  = 1'b1;
      cmpl_ray_id = RAY_W'($urandom);
      cmpl_hitT   = $urandom;
    end
  endtask

  task automatic run_until_idle(input int lat, input int cpct, input int rpct,
                                input bit inorder, input bit noise);
    int n;
    n = 0;
    while (m_busy && n < 400) begin
      issue_ready = ($urandom_range(99) < rpct);
      drive_cmpl(lat, cpct, inorder, noise);
      start    = noise && ($urandom_range(7) == 0);
      num_rays = RAY_W'($urandom);
      cycle();
      n++;
    end
    start = 1'b0; cmpl_valid = 1'b0; num_rays = '0;
    check("batch_end_busy", busy, 1'b0);
  endtask

  task automatic run_batch(input int num, input int lat, input int cpct, input int rpct,
                           input bit inorder, input bit noise);
    w_cnt = 0; d_cnt = 0;
    start = 1'b1; num_rays = RAY_W'(num); cmpl_valid = 1'b0;
    issue_ready = ($urandom_range(99) < rpct);
    cycle();
    start = 1'b0;
    run_until_idle(lat, cpct, rpct, inorder, noise);
    check("batch_writes", w_cnt, num);
    check("batch_done_pulses", d_cnt, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_rays = '0; issue_ready = 1'b0;
    cmpl_valid = 1'b0; cmpl_ray_id = '0; cmpl_hitT = '0;
    cycle(); cycle();
    reset = 1'b0;
    cycle();

    // Four rays, always ready, in-order completion three cycles after issue.
    run_batch(4, 3, 100, 100, 1'b1, 1'b0);

    // Credit cap: no completions, issuing stalls at MAXI outstanding.
    start = 1'b1; num_rays = 16'd6; issue_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (6) cycle();
    check("cap_valid", issue_valid, 1'b0);
    check("cap_inflight", inflight, MAXI);
    cmpl_valid = 1'b1; cmpl_ray_id = RAY_W'(pend_id.pop_front()); cmpl_hitT = $urandom;
    void'(pend_t.pop_front());
    cycle();
    cmpl_valid = 1'b0;
    check("cap_reissue_valid", issue_valid, 1'b1);
    check("cap_reissue_id", issue_ray_id, 16'd4);
    run_until_idle(2, 60, 100, 1'b0, 1'b0);

    // Same-cycle issue and completion at inflight 1.
    start = 1'b1; num_rays = 16'd3; issue_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cmpl_valid = 1'b1; cmpl_ray_id = RAY_W'(pend_id.pop_front()); cmpl_hitT = 32'h3F80_0000;
    void'(pend_t.pop_front());
    cycle();
    cmpl_valid = 1'b0;
    check("same_cycle_inflight", inflight, 1);
    check("same_cycle_we", res_we, 1'b1);
    check("same_cycle_data", res_data, 32'h3F80_0000);
    run_until_idle(2, 100, 100, 1'b1, 1'b0);

    // Empty batch.
    start = 1'b1; num_rays = '0;
    cycle();
    start = 1'b0;
    check("empty_done", done, 1'b1);
    check("empty_valid", issue_valid, 1'b0);
    cycle();
    check("empty_idle", busy, 1'b0);

    // Completion with nothing outstanding.
    start = 1'b1; num_rays = 16'd2; issue_ready = 1'b0;
    cycle();
    start = 1'b0;
    cmpl_valid = 1'b1; cmpl_ray_id = 16'd7; cmpl_hitT = $urandom;
    cycle();
    cmpl_valid = 1'b0;
    check("spurious_err", err, 1'b1);
    check("spurious_inflight", inflight, 0);
    check("spurious_we", res_we, 1'b0);
    run_until_idle(1, 100, 100, 1'b1, 1'b0);

    // Reset while draining with three outstanding.
    start = 1'b1; num_rays = 16'd3; issue_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    check("drain_inflight", inflight, 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_inflight", inflight, 0);
    check("abort_done", done, 1'b0);
    cycle();

    // Five stalled cycles at the start of a batch.
    start = 1'b1; num_rays = 16'd2; issue_ready = 1'b0;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    run_until_idle(1, 100, 100, 1'b1, 1'b0);
`ifdef RTP_PERF_CNT_EN
    check("perf_stalls_5", perf_stalls, 5);
`endif

    for (int b = 0; b < 40; b++) begin
      run_batch($urandom_range(12), $urandom_range(1, 5), $urandom_range(20, 100),
                $urandom_range(10, 100), 1'($urandom_range(1)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
